axis_rr_arbiter: RTL

Round-robin, packet-locked arbiter that shares one 8-bit AXI-Stream register stage between NUM_SRC upstream requesters. Sits in front of the 8-bit AXI register datapath. Grants one source at a time and holds the grant until that source's s_last beat is accepted, so packets never interleave. Drives a single registered master port.

---
 rtl/axis_arb_pkg.sv | 15 +
 rtl/rr_priority_pick.sv | 32 +++
 rtl/axis_rr_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and defaults for the round-robin AXI-Stream arbiter.
// Holds the arbitration state encoding and the default geometry.
package axis_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    localparam int NUM_SRC_DEF     = 4;
    localparam int DATA_W_DEF      = 8;
    localparam int TIMEOUT_CYC_DEF = 16;
    localparam int GRANT_W         = $clog2(NUM_SRC_DEF);

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: first requester at or after last_grant+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
module rr_priority_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int GRANT_W = GRANT_W
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [GRANT_W-1:0] last_grant_i,
    output logic [GRANT_W-1:0] grant_o,
    output logic               any_req_o
);

    logic [GRANT_W-1:0] idx;

    // Walk from the farthest slot back to the nearest so the nearest requester wins.
    always_comb begin
        grant_o = '0;
        idx     = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = GRANT_W'((int'(last_grant_i) + k) % NUM_SRC);
            if (req_i[idx]) begin
                grant_o = idx;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin packet-locked arbiter onto one registered AXI-Stream port; AXIS_ARB_TIMEOUT_EN adds stall release.
// Latency: request to grant 1 cycle, accepted beat to m_* 1 cycle (one IDLE cycle per packet boundary).
// Backpressure: granted s_ready = !m_valid || m_ready (combinational); all other s_ready held low.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC     = NUM_SRC_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC*DATA_W-1:0]  s_data,
    input  logic [NUM_SRC-1:0]         s_valid,
    input  logic [NUM_SRC-1:0]         s_last,
    output logic [NUM_SRC-1:0]         s_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_valid,
    output logic                       m_last,
    input  logic                       m_ready,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic                       err_timeout
);

    localparam int GW = $clog2(NUM_SRC);

    arb_state_e        state_q;
    logic [GW-1:0]     grant_q;
    logic [GW-1:0]     last_grant_q;
    logic [GW-1:0]     pick_idx;
    logic              any_req;
    logic [DATA_W-1:0] m_data_q;
    logic              m_valid_q;
    logic              m_last_q;
    logic              err_q;

    logic              out_free;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              accept;
    logic              stall_expire;

    rr_priority_pick #(
        .NUM_SRC (NUM_SRC),
        .GRANT_W (GW)
    ) u_pick (
        .req_i        (s_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_idx),
        .any_req_o    (any_req)
    );

    assign out_free  = !m_valid_q || m_ready;
    assign sel_valid = s_valid[grant_q];
    assign sel_last  = s_last[grant_q];
    assign accept    = (state_q == ARB_LOCK) && sel_valid && out_free;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == GW'(i)) begin
                sel_data = s_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        s_ready = '0;
        if (state_q == ARB_LOCK) begin
            s_ready[grant_q] = out_free;
        end
    end

`ifdef AXIS_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYC + 1);

    logic [SW-1:0] stall_q;
    logic [SW-1:0] stall_d;

    // Only cycles where the owner has nothing to offer count; downstream stalls do not.
    always_comb begin
        stall_d      = stall_q;
        stall_expire = 1'b0;
        if (state_q != ARB_LOCK || accept) begin
            stall_d = '0;
        end else if (!sel_valid) begin
            if (stall_q == SW'(TIMEOUT_CYC - 1)) begin
                stall_expire = 1'b1;
                stall_d      = '0;
            end else begin
                stall_d = stall_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign stall_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_SRC - 1);
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= 1'b0;

            if (accept) begin
                m_data_q  <= sel_data;
                m_last_q  <= sel_last;
                m_valid_q <= 1'b1;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end

            case (state_q)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant_q <= pick_idx;
                        state_q <= ARB_LOCK;
                    end
                end
                ARB_LOCK: begin
                    if (accept && sel_last) begin
                        last_grant_q <= grant_q;
                        state_q      <= ARB_IDLE;
                    end else if (stall_expire) begin
                        // Abandoned packet leaves downstream without m_last.
                        last_grant_q <= grant_q;
                        state_q      <= ARB_IDLE;
                        err_q        <= 1'b1;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q == ARB_LOCK);
    assign err_timeout = err_q;

endmodule
